// File: rtl/connect_resp_steer_if.sv
// Handshake/response bundle between the request mux, XHB and the two response consumers.
// Signal names are from the steering block's point of view (slave modport).
interface connect_resp_steer_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8
);
  logic                      ENABLE_i;
  logic                      AR_HS_i;
  logic                      AW_HS_i;
  logic                      AR_STALL_o;
  logic                      AW_STALL_o;

  logic                      RVALID_i;
  logic                      RLAST_i;
  logic [DATA_W-1:0]         RDATA_i;
  logic                      RREADY_o;

  logic                      EN_RVALID_o;
  logic                      EN_RLAST_o;
  logic [DATA_W-1:0]         EN_RDATA_o;
  logic                      EN_RREADY_i;

  logic                      AC_RVALID_o;
  logic                      AC_RLAST_o;
  logic [DATA_W-1:0]         AC_RDATA_o;
  logic                      AC_RREADY_i;

  logic                      BVALID_i;
  logic [1:0]                BRESP_i;
  logic                      BREADY_o;

  logic                      EN_BVALID_o;
  logic                      AC_BVALID_o;
  logic [1:0]                EN_BRESP_o;
  logic [1:0]                AC_BRESP_o;
  logic                      EN_BREADY_i;
  logic                      AC_BREADY_i;

  logic [$clog2(DEPTH):0]    AR_OUTST_o;
  logic [$clog2(DEPTH):0]    AW_OUTST_o;
  logic                      ERR_o;

  modport slave (
    input  ENABLE_i, AR_HS_i, AW_HS_i,
    input  RVALID_i, RLAST_i, RDATA_i,
    input  EN_RREADY_i, AC_RREADY_i,
    input  BVALID_i, BRESP_i,
    input  EN_BREADY_i, AC_BREADY_i,
    output AR_STALL_o, AW_STALL_o, RREADY_o,
    output EN_RVALID_o, EN_RLAST_o, EN_RDATA_o,
    output AC_RVALID_o, AC_RLAST_o, AC_RDATA_o,
    output BREADY_o, EN_BVALID_o, AC_BVALID_o, EN_BRESP_o, AC_BRESP_o,
    output AR_OUTST_o, AW_OUTST_o, ERR_o
  );

  modport master (
    output ENABLE_i, AR_HS_i, AW_HS_i,
    output RVALID_i, RLAST_i, RDATA_i,
    output EN_RREADY_i, AC_RREADY_i,
    output BVALID_i, BRESP_i,
    output EN_BREADY_i, AC_BREADY_i,
    input  AR_STALL_o, AW_STALL_o, RREADY_o,
    input  EN_RVALID_o, EN_RLAST_o, EN_RDATA_o,
    input  AC_RVALID_o, AC_RLAST_o, AC_RDATA_o,
    input  BREADY_o, EN_BVALID_o, AC_BVALID_o, EN_BRESP_o, AC_BRESP_o,
    input  AR_OUTST_o, AW_OUTST_o, ERR_o
  );
endinterface

// File: rtl/connect_resp_steer.sv
// Records the path (AIDC vs engine) of each accepted AR/AW and steers the in-order
// R/B responses from XHB back to the consumer that issued the address.

module connect_resp_steer_tagq #(
  parameter int DEPTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic                   tag_i,
  input  logic                   pop_i,
  output logic                   head_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic                   drop_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DEPTH-1:0] mem_q, mem_d;
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_q];
  assign count_o = count_q;

  always_comb begin
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    // A push while full is dropped, even if a pop frees a slot in the same cycle.
    push_ok = push_i & ~full_o;
    pop_ok  = pop_i & ~empty_o;
    drop_o  = push_i & full_o;
    if (push_ok) begin
      mem_d[wr_q] = tag_i;
      wr_d        = wr_q + PTR_W'(1);
    end
    if (pop_ok) begin
      rd_d = rd_q + PTR_W'(1);
    end
    if (push_ok && !pop_ok) begin
      count_d = count_q + CNT_W'(1);
    end else if (!push_ok && pop_ok) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end
endmodule

module connect_resp_steer #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8
) (
  input  logic                CLK_i,
  input  logic                RSTN_i,
  connect_resp_steer_if.slave bus
);
  logic r_head, r_full, r_empty, r_drop, r_pop, r_ready;
  logic w_head, w_full, w_empty, w_drop, w_pop, w_ready;
  logic r_sel_ac, r_sel_en, w_sel_ac, w_sel_en;
  logic [$clog2(DEPTH):0] r_count, w_count;
  logic err_q, err_d;

  connect_resp_steer_tagq #(.DEPTH(DEPTH)) u_rtag (
    .clk_i   (CLK_i),
    .rst_ni  (RSTN_i),
    .push_i  (bus.AR_HS_i),
    .tag_i   (bus.ENABLE_i),
    .pop_i   (r_pop),
    .head_o  (r_head),
    .full_o  (r_full),
    .empty_o (r_empty),
    .drop_o  (r_drop),
    .count_o (r_count)
  );

  connect_resp_steer_tagq #(.DEPTH(DEPTH)) u_wtag (
    .clk_i   (CLK_i),
    .rst_ni  (RSTN_i),
    .push_i  (bus.AW_HS_i),
    .tag_i   (bus.ENABLE_i),
    .pop_i   (w_pop),
    .head_o  (w_head),
    .full_o  (w_full),
    .empty_o (w_empty),
    .drop_o  (w_drop),
    .count_o (w_count)
  );

  // An empty tag store selects neither path, which also blocks XHB.
  assign r_sel_ac = ~r_empty & r_head;
  assign r_sel_en = ~r_empty & ~r_head;
  assign w_sel_ac = ~w_empty & w_head;
  assign w_sel_en = ~w_empty & ~w_head;

  assign r_ready = (r_sel_ac & bus.AC_RREADY_i) | (r_sel_en & bus.EN_RREADY_i);
  assign w_ready = (w_sel_ac & bus.AC_BREADY_i) | (w_sel_en & bus.EN_BREADY_i);
  assign r_pop   = bus.RVALID_i & r_ready & bus.RLAST_i;
  assign w_pop   = bus.BVALID_i & w_ready;

  assign bus.RREADY_o    = r_ready;
  assign bus.AC_RVALID_o = r_sel_ac & bus.RVALID_i;
  assign bus.EN_RVALID_o = r_sel_en & bus.RVALID_i;
  assign bus.AC_RLAST_o  = r_sel_ac & bus.RLAST_i;
  assign bus.EN_RLAST_o  = r_sel_en & bus.RLAST_i;
  assign bus.AC_RDATA_o  = r_sel_ac ? bus.RDATA_i : '0;
  assign bus.EN_RDATA_o  = r_sel_en ? bus.RDATA_i : '0;

  assign bus.BREADY_o    = w_ready;
  assign bus.AC_BVALID_o = w_sel_ac & bus.BVALID_i;
  assign bus.EN_BVALID_o = w_sel_en & bus.BVALID_i;
  assign bus.AC_BRESP_o  = w_sel_ac ? bus.BRESP_i : '0;
  assign bus.EN_BRESP_o  = w_sel_en ? bus.BRESP_i : '0;

  assign bus.AR_STALL_o  = r_full;
  assign bus.AW_STALL_o  = w_full;
  assign bus.AR_OUTST_o  = r_count;
  assign bus.AW_OUTST_o  = w_count;
  assign bus.ERR_o       = err_q;

  always_comb begin
    err_d = err_q | r_drop | w_drop
          | (bus.RVALID_i & r_empty) | (bus.BVALID_i & w_empty);
  end

  always_ff @(posedge CLK_i or negedge RSTN_i) begin
    if (!RSTN_i) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
endmodule
